// File: rtl/blt_cmd_pkg.sv
// Blitter command queue shared types and bit positions.
// Optional status extension macro: BLT_QUEUE_STATUS_EN.
package blt_cmd_pkg;

  typedef struct packed {
    logic srcenf;
    logic dsten;
    logic srcen;
    logic dstup;
    logic srcup;
    logic parrd;
    logic colst;
    logic run;
  } cmd_t;

  localparam int CTL_RESUME_BIT = 1;
  localparam int CTL_SRESET_BIT = 2;
  localparam int MOD_LINDR_BIT  = 3;
  localparam int MOD_RES_LSB    = 5;

  localparam int STA_STOP_BIT   = 1;
  localparam int STA_ICNT8_BIT  = 2;
  localparam int STA_QFULL_BIT  = 3;
  localparam int STA_OVF_BIT    = 4;
  localparam int STA_RUN_BIT    = 5;
  localparam int STA_QCNT_LSB   = 6;

  function automatic logic [1:0] sat3(input logic [3:0] c);
    return (c > 4'd3) ? 2'd3 : c[1:0];
  endfunction

endpackage

// File: rtl/blt_cmd_fifo.sv
// Pending-command FIFO for the blitter queue.
// Push and pop may coincide, including when full.
module blt_cmd_fifo
  import blt_cmd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  cmd_t             data_i,
  input  logic             pop_i,
  output cmd_t             data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  // Pointer and occupancy next-state.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = nxt(rd_q);
    if (do_push) wr_d = nxt(wr_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; flush empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/blt_cmd_queue.sv
// Blitter command/mode/control registers with a pending-command queue.
// Define BLT_QUEUE_STATUS_EN to expose QFULL/OVF/RUN/QCOUNT in status.
module blt_cmd_queue
  import blt_cmd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CCLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] ID,
  input  logic              CMDWRL,
  input  logic              LDCMDL,
  input  logic              LDMODL,
  input  logic              CONWRL,
  input  logic              STRD,
  input  logic              STOP,
  input  logic              ICNT_8,
  input  logic              DONE,
  output logic              RUN,
  output logic              COLST,
  output logic              PARRD,
  output logic              SRCUP,
  output logic              DSTUP,
  output logic              SRCEN,
  output logic              DSTEN,
  output logic              SRCENF,
  output logic              LINDR,
  output logic [1:0]        RES,
  output logic              RESUME,
  output logic              SRESET,
  output logic [DATA_W-1:0] STAT_D,
  output logic              STAT_EN,
  output logic              QFULL,
  output logic [CNT_W-1:0]  QCOUNT
);

  logic [7:0]       id8;
  logic             cmd_ld, con_wr;
  logic             cmd_prev_q, con_prev_q;
  logic             cmd_fire, con_fire;
  cmd_t             active_q, active_d;
  cmd_t             head;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] count;
  logic             resume_q, resume_d;
  logic             sreset_q, sreset_d;
  logic             lindr_q, lindr_d;
  logic [1:0]       res_q, res_d;
  logic [DATA_W-1:0] stat;
`ifdef BLT_QUEUE_STATUS_EN
  logic             ovf_q, ovf_set;
`endif

  assign id8      = ID[7:0];
  assign cmd_ld   = ~CMDWRL | ~LDCMDL;
  assign con_wr   = ~CONWRL;
  assign cmd_fire = cmd_ld & ~cmd_prev_q;
  assign con_fire = con_wr & ~con_prev_q;

  blt_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (CCLK),
    .rst_i   (RESET),
    .flush_i (sreset_q),
    .push_i  (push),
    .data_i  (cmd_t'(id8)),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Active command promotion, queue push/pop and overflow detection.
  always_comb begin
    active_d = active_q;
    push     = 1'b0;
    pop      = 1'b0;
`ifdef BLT_QUEUE_STATUS_EN
    ovf_set  = 1'b0;
`endif
    if (sreset_q) begin
      active_d = '0;
    end else if (DONE) begin
      if (!empty) begin
        active_d = head;
        pop      = 1'b1;
        push     = cmd_fire;
      end else if (cmd_fire) begin
        active_d = cmd_t'(id8);
      end else begin
        active_d.run = 1'b0;
      end
    end else if (cmd_fire) begin
      if (!active_q.run && empty) begin
        active_d = cmd_t'(id8);
      end else if (full) begin
`ifdef BLT_QUEUE_STATUS_EN
        ovf_set = 1'b1;
`endif
      end else begin
        push = 1'b1;
      end
    end
  end

  // Pulse generation and mode register next-state.
  always_comb begin
    sreset_d = con_fire & id8[CTL_SRESET_BIT];
    resume_d = con_fire & id8[CTL_RESUME_BIT] & ~id8[CTL_SRESET_BIT];
    lindr_d  = lindr_q;
    res_d    = res_q;
    if (!LDMODL) begin
      lindr_d = id8[MOD_LINDR_BIT];
      res_d   = id8[MOD_RES_LSB +: 2];
    end
  end

  // Command, mode, pulse and strobe-history registers.
  always_ff @(posedge CCLK) begin
    if (RESET) begin
      active_q   <= '0;
      lindr_q    <= 1'b0;
      res_q      <= 2'b00;
      resume_q   <= 1'b0;
      sreset_q   <= 1'b0;
      cmd_prev_q <= cmd_ld;
      con_prev_q <= con_wr;
    end else begin
      active_q   <= active_d;
      lindr_q    <= lindr_d;
      res_q      <= res_d;
      resume_q   <= resume_d;
      sreset_q   <= sreset_d;
      cmd_prev_q <= cmd_ld;
      con_prev_q <= con_wr;
    end
  end

`ifdef BLT_QUEUE_STATUS_EN
  // Sticky overflow flag for dropped command writes.
  always_ff @(posedge CCLK) begin
    if (RESET || sreset_q) ovf_q <= 1'b0;
    else if (ovf_set)      ovf_q <= 1'b1;
  end
`endif

  // Status word assembly.
  always_comb begin
    stat                = '0;
    stat[STA_STOP_BIT]  = STOP;
    stat[STA_ICNT8_BIT] = ICNT_8;
`ifdef BLT_QUEUE_STATUS_EN
    stat[STA_QFULL_BIT]      = full;
    stat[STA_OVF_BIT]        = ovf_q;
    stat[STA_RUN_BIT]        = active_q.run;
    stat[STA_QCNT_LSB +: 2]  = sat3(4'(count));
`endif
  end

  assign RUN     = active_q.run;
  assign COLST   = active_q.colst;
  assign PARRD   = active_q.parrd;
  assign SRCUP   = active_q.srcup;
  assign DSTUP   = active_q.dstup;
  assign SRCEN   = active_q.srcen;
  assign DSTEN   = active_q.dsten;
  assign SRCENF  = active_q.srcenf;
  assign LINDR   = lindr_q;
  assign RES     = res_q;
  assign RESUME  = resume_q;
  assign SRESET  = sreset_q;
  assign STAT_D  = stat;
  assign STAT_EN = STRD;
  assign QFULL   = full;
  assign QCOUNT  = count;

endmodule
